// File: rtl/sap_pkg.sv
// Shared constants and ALU op encoding for the SAP datapath slice.
// No logic, so it has no latency.
// No flow control: the package has no handshake of its own.
package sap_pkg;

  localparam int DW  = 8;
  localparam int PCW = 4;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

endpackage

// File: rtl/sap_datapath_core_if.sv
// System-bus bundle exchanged between the datapath slice and external sources.
// Latency: combinational wires, none added.
// Backpressure: none; the control unit arbitrates the bus by cycle.
interface sap_datapath_core_if #(parameter int DW = 8);

  logic [DW-1:0] bus_in;
  logic [DW-1:0] bus_out;
  logic          bus_oe;

  // Datapath side: drives bus_out/bus_oe, sees what external sources drive.
  modport master (input bus_in, output bus_out, output bus_oe);

  // System side: drives bus_in, observes the datapath's contribution.
  modport slave (output bus_in, input bus_out, input bus_oe);

endinterface

// File: rtl/sap_reg.sv
// Generic load register with synchronous clear (used for A and B).
// Latency: one cycle from d/we to q.
// Backpressure: none; loads whenever we is high, clr wins over we.
module sap_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear dominates; otherwise load on write-enable, else hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      q <= '0;
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/sap_datapath_core.sv
// SAP datapath slice: PC, A/B registers, add/sub ALU with latched flags on one shared bus.
// Latency: bus_out/bus_oe combinational; pc_q/a_q/b_q/cf/zf update one edge after enables.
// Backpressure: none; the control unit owns the enables every cycle, clr overrides all.
module sap_datapath_core
  import sap_pkg::*;
#(
  parameter int DW  = sap_pkg::DW,
  parameter int PCW = sap_pkg::PCW
) (
  input  logic                  clk,
  input  logic                  clr,
  sap_datapath_core_if.master   sys,
  input  logic                  pc_oe,
  input  logic                  pc_jmp,
  input  logic                  pc_inc,
  input  logic                  a_we,
  input  logic                  a_oe,
  input  logic                  b_we,
  input  logic                  b_oe,
  input  logic                  sum_oe,
  input  logic                  sub,
  input  logic                  flags_we,
  output logic [PCW-1:0]        pc_q,
  output logic [DW-1:0]         a_q,
  output logic [DW-1:0]         b_q,
  output logic                  cf,
  output logic                  zf
);

  logic [DW-1:0] bus_int;
  logic [DW-1:0] pc_ext;
  logic [DW-1:0] b_op;
  logic [DW:0]   alu_full;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          is_sub;

  // ALU: subtract is A + ~B + 1, so the carry out means "no borrow".
  always_comb begin
    is_sub   = (sub == ALU_SUB);
    b_op     = is_sub ? ~b_q : b_q;
    alu_full = {1'b0, a_q} + {1'b0, b_op} + {{DW{1'b0}}, is_sub};
    alu_res  = alu_full[DW-1:0];
    alu_c    = alu_full[DW];
  end

  // Shared bus: fixed priority PC > A > B > ALU, falls back to the external bus.
  always_comb begin
    pc_ext            = '0;
    pc_ext[PCW-1:0]   = pc_q;
    bus_int           = sys.bus_in;
    if (pc_oe) begin
      bus_int = pc_ext;
    end else if (a_oe) begin
      bus_int = a_q;
    end else if (b_oe) begin
      bus_int = b_q;
    end else if (sum_oe) begin
      bus_int = alu_res;
    end
  end

  assign sys.bus_out = bus_int;
  assign sys.bus_oe  = pc_oe | a_oe | b_oe | sum_oe;

  // Program counter: clear, then jump, then increment (wraps naturally).
  always_ff @(posedge clk) begin
    if (clr) begin
      pc_q <= '0;
    end else if (pc_jmp) begin
      pc_q <= bus_int[PCW-1:0];
    end else if (pc_inc) begin
      pc_q <= pc_q + 1'b1;
    end
  end

  // Flags capture the pre-edge ALU outcome only when asked.
  always_ff @(posedge clk) begin
    if (clr) begin
      cf <= 1'b0;
      zf <= 1'b0;
    end else if (flags_we) begin
      cf <= alu_c;
      zf <= (alu_res == '0);
    end
  end

  sap_reg #(.W(DW)) u_reg_a (
    .clk (clk),
    .clr (clr),
    .we  (a_we),
    .d   (bus_int),
    .q   (a_q)
  );

  sap_reg #(.W(DW)) u_reg_b (
    .clk (clk),
    .clr (clr),
    .we  (b_we),
    .d   (bus_int),
    .q   (b_q)
  );

endmodule

// File: tb/tb_sap_datapath_core.sv
// Directed bench for sap_datapath_core with a queued scoreboard.
// Stimulus pushes expectations right after each edge; the monitor checks them mid-cycle.
// No flow control on the DUT, so the monitor drains the queue every falling edge.
module tb_sap_datapath_core;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       pc_oe = 1'b0, pc_jmp = 1'b0, pc_inc = 1'b0;
  logic       a_we = 1'b0, a_oe = 1'b0, b_we = 1'b0, b_oe = 1'b0;
  logic       sum_oe = 1'b0, sub = 1'b0, flags_we = 1'b0;
  logic [3:0] pc_q;
  logic [7:0] a_q, b_q;
  logic       cf, zf;

  sap_datapath_core_if #(.DW(8)) sys_if ();

  sap_datapath_core dut (
    .clk      (clk),
    .clr      (clr),
    .sys      (sys_if.master),
    .pc_oe    (pc_oe),
    .pc_jmp   (pc_jmp),
    .pc_inc   (pc_inc),
    .a_we     (a_we),
    .a_oe     (a_oe),
    .b_we     (b_we),
    .b_oe     (b_oe),
    .sum_oe   (sum_oe),
    .sub      (sub),
    .flags_we (flags_we),
    .pc_q     (pc_q),
    .a_q      (a_q),
    .b_q      (b_q),
    .cf       (cf),
    .zf       (zf)
  );

  always #5 clk = ~clk;

  localparam logic [10:0] C_CLR   = 11'h001;
  localparam logic [10:0] C_PCOE  = 11'h002;
  localparam logic [10:0] C_JMP   = 11'h004;
  localparam logic [10:0] C_INC   = 11'h008;
  localparam logic [10:0] C_AWE   = 11'h010;
  localparam logic [10:0] C_AOE   = 11'h020;
  localparam logic [10:0] C_BWE   = 11'h040;
  localparam logic [10:0] C_BOE   = 11'h080;
  localparam logic [10:0] C_SUMOE = 11'h100;
  localparam logic [10:0] C_SUB   = 11'h200;
  localparam logic [10:0] C_FLG   = 11'h400;

  localparam int S_BUS = 0, S_OE = 1, S_PC = 2, S_A = 3, S_B = 4, S_CF = 5, S_ZF = 6;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Wait for the next rising edge, then present a new set of inputs.
  task automatic go(input logic [7:0] bi, input logic [10:0] m);
    @(posedge clk);
    #1;
    sys_if.bus_in = bi;
    clr      = m[0];
    pc_oe    = m[1];
    pc_jmp   = m[2];
    pc_inc   = m[3];
    a_we     = m[4];
    a_oe     = m[5];
    b_we     = m[6];
    b_oe     = m[7];
    sum_oe   = m[8];
    sub      = m[9];
    flags_we = m[10];
  endtask

  task automatic chk(input string name, input int sel, input logic [7:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    sbq.push_back(e);
  endtask

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      S_BUS:   return sys_if.bus_out;
      S_OE:    return {7'd0, sys_if.bus_oe};
      S_PC:    return {4'd0, pc_q};
      S_A:     return a_q;
      S_B:     return b_q;
      S_CF:    return {7'd0, cf};
      default: return {7'd0, zf};
    endcase
  endfunction

  // Monitor: mid-cycle, compare every pending expectation against the DUT.
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = observe(e.sel);
        total++;
        if (act !== e.val) begin
          bad++;
          $display("FAIL %s: got %h want %h", e.name, act, e.val);
        end
      end
    end
  end

  initial begin
    sys_if.bus_in = 8'h00;

    // Reset state
    go(8'h00, C_CLR);
    go(8'h00, C_CLR);
    go(8'h00, '0);
    chk("rst_pc", S_PC, 8'h00); chk("rst_a", S_A, 8'h00); chk("rst_b", S_B, 8'h00);
    chk("rst_cf", S_CF, 8'h00); chk("rst_zf", S_ZF, 8'h00);
    chk("idle_bus", S_BUS, 8'h00); chk("idle_oe", S_OE, 8'h00);

    // Preload non-zero state, then clear it with every enable also asserted
    go(8'h80, C_AWE);
    go(8'h80, C_BWE);
    go(8'h00, C_FLG);                     // 0x80+0x80 = 0x100 -> cf=1 zf=1
    go(8'h55, C_AWE);
    chk("pre_cf", S_CF, 8'h01); chk("pre_zf", S_ZF, 8'h01);
    go(8'hAA, C_BWE);
    go(8'h07, C_JMP);
    go(8'h11, C_CLR | C_AOE | C_AWE | C_BWE | C_INC | C_FLG);
    chk("pre_a", S_A, 8'h55); chk("pre_b", S_B, 8'hAA); chk("pre_pc", S_PC, 8'h07);
    chk("clr_bus", S_BUS, 8'h55); chk("clr_oe", S_OE, 8'h01);
    go(8'h00, '0);
    chk("clr_pc", S_PC, 8'h00); chk("clr_a", S_A, 8'h00); chk("clr_b", S_B, 8'h00);
    chk("clr_cf", S_CF, 8'h00); chk("clr_zf", S_ZF, 8'h00);

    // Load and add in place
    go(8'h38, C_AWE);
    go(8'h23, C_BWE);
    chk("ld_a", S_A, 8'h38);
    go(8'h00, C_SUMOE | C_AWE | C_FLG);
    chk("ld_b", S_B, 8'h23); chk("add_bus", S_BUS, 8'h5B); chk("add_oe", S_OE, 8'h01);
    go(8'h00, C_AOE);
    chk("add_a", S_A, 8'h5B); chk("add_cf", S_CF, 8'h00); chk("add_zf", S_ZF, 8'h00);
    chk("aoe_bus", S_BUS, 8'h5B);

    // Subtract cases
    go(8'h38, C_AWE);
    go(8'h23, C_BWE);
    go(8'h00, C_SUMOE | C_SUB | C_FLG);
    chk("sub1_bus", S_BUS, 8'h15);
    go(8'h23, C_AWE);
    chk("sub1_cf", S_CF, 8'h01); chk("sub1_zf", S_ZF, 8'h00);
    go(8'h00, C_SUMOE | C_SUB | C_FLG);
    chk("sub2_bus", S_BUS, 8'h00);
    go(8'h00, C_AWE);
    chk("sub2_cf", S_CF, 8'h01); chk("sub2_zf", S_ZF, 8'h01);
    go(8'h01, C_BWE);
    go(8'h00, C_SUMOE | C_SUB | C_FLG);
    chk("sub3_a", S_A, 8'h00); chk("sub3_b", S_B, 8'h01); chk("sub3_bus", S_BUS, 8'hFF);
    go(8'hF0, C_AWE);
    chk("sub3_cf", S_CF, 8'h00); chk("sub3_zf", S_ZF, 8'h00);

    // Add overflow
    go(8'h20, C_BWE);
    go(8'h00, C_SUMOE | C_FLG);
    chk("ovf1_bus", S_BUS, 8'h10);
    go(8'h80, C_AWE);
    chk("ovf1_cf", S_CF, 8'h01); chk("ovf1_zf", S_ZF, 8'h00);
    go(8'h80, C_BWE);
    go(8'h00, C_SUMOE | C_FLG);
    chk("ovf2_bus", S_BUS, 8'h00);
    go(8'h00, '0);
    chk("ovf2_cf", S_CF, 8'h01); chk("ovf2_zf", S_ZF, 8'h01);

    // Program counter
    go(8'hEE, C_PCOE | C_INC);
    chk("pcoe_pc", S_PC, 8'h00); chk("pcoe_bus", S_BUS, 8'h00); chk("pcoe_oe", S_OE, 8'h01);
    go(8'h00, '0);
    chk("pcinc_pc", S_PC, 8'h01);
    go(8'h0F, C_JMP);
    go(8'h00, C_INC);
    chk("pcjmp_pc", S_PC, 8'h0F);
    go(8'h00, '0);
    chk("pcwrap_pc", S_PC, 8'h00);
    go(8'h3C, C_JMP | C_INC);
    go(8'h00, '0);
    chk("jmpwin_pc", S_PC, 8'h0C);

    // Bus priority
    go(8'h5B, C_AWE);
    go(8'h00, C_PCOE | C_AOE);
    chk("prio_a", S_A, 8'h5B); chk("prio_pc_a", S_BUS, 8'h0C);
    go(8'h00, C_AOE | C_BOE | C_SUMOE);
    chk("prio_a_b", S_BUS, 8'h5B);
    go(8'h00, C_BOE | C_SUMOE);
    chk("prio_b_sum", S_BUS, 8'h80);

    // Hold with no enables; external bus passes through
    for (int i = 0; i < 4; i++) begin
      go(8'h77, '0);
      chk("hold_bus", S_BUS, 8'h77); chk("hold_oe", S_OE, 8'h00);
    end
    chk("hold_pc", S_PC, 8'h0C); chk("hold_a", S_A, 8'h5B); chk("hold_b", S_B, 8'h80);
    chk("hold_cf", S_CF, 8'h01); chk("hold_zf", S_ZF, 8'h01);
    go(8'h00, C_AOE);
    chk("hold_aoe", S_BUS, 8'h5B);

    @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap_datapath_core.md
Name: sap_datapath_core

Overview:
- 8-bit single-bus datapath slice for the SAP-style CPU: 4-bit program counter, general-purpose registers A and B, and an add/subtract ALU with latched carry/zero flags.
- All blocks share one internal 8-bit bus that is also exchanged with the external system bus (RAM, MAR, IR, output register).
- The control unit drives the enables each cycle.

Parameters:
- DW, 8, data/bus width.
- PCW, 4, program counter width (PCW ≤ DW).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- clr  in  1  reset. Synchronous, active-high, and overrides all enables.
- bus_in  in  DW  value driven onto the system bus by external sources.
- bus_out  out  DW  value this block drives onto the system bus.
- bus_oe  out  1  high when any internal source drives the bus.
- pc_oe  in  1  PC drives the bus.
- pc_jmp  in  1  PC loads the bus.
- pc_inc  in  1  PC increments.
- a_we  in  1  A loads the bus.
- a_oe  in  1  A drives the bus.
- b_we  in  1  B loads the bus.
- b_oe  in  1  B drives the bus.
- sum_oe  in  1  ALU result drives the bus.
- sub  in  1  ALU mode: 0 = A+B, 1 = A−B.
- flags_we  in  1  latch cf/zf.
- pc_q  out  PCW  PC value.
- a_q  out  DW  A value.
- b_q  out  DW  B value.
- cf  out  1  latched carry flag.
- zf  out  1  latched zero flag.

Behaviour:
- Internal bus (combinational), fixed drive priority: pc_oe, then a_oe, then b_oe, then sum_oe.
  - pc_oe selects {zero-extend, pc_q}.
  - If no internal source is enabled, the internal bus equals bus_in.
- bus_out equals the internal bus. bus_oe = pc_oe | a_oe | b_oe | sum_oe.
- ALU is combinational from a_q/b_q.
  - sub=0: {c, r} = a_q + b_q.
  - sub=1: {c, r} = a_q + ~b_q + 1. Carry = no-borrow, so cf=1 when a_q ≥ b_q.
  - Result is DW bits and wraps modulo 2^DW.
- Flags: on a rising edge with flags_we=1, cf <= c and zf <= (r == 0). Otherwise they hold.
- A and B: on a rising edge with the write-enable high, the register loads the internal bus.
  - a_we with sum_oe in the same cycle loads the pre-edge ALU result (A <= A+B in one cycle).
- PC on a rising edge, in priority order:
  - clr: pc_q <= 0.
  - pc_jmp: pc_q <= internal bus[PCW-1:0].
  - pc_inc: pc_q <= pc_q + 1, wrapping F to 0.
  - otherwise hold.
- pc_oe with pc_inc in the same cycle drives the old value; the increment is visible next cycle.
- Reset: when clr=1 at an edge, pc_q, a_q, b_q, cf and zf all become 0, regardless of other enables.
  - Reset mid-sequence discards pending loads.
  - bus_out still reflects the combinational sources while clr is asserted.
- Outputs are registered except bus_out and bus_oe (combinational).
- Multiple oe high at once is a control error; the priority above defines the result.

Decomposition:
- Shared package sap_pkg holds: DW/PCW constants and the ALU op encoding (ALU_ADD=0, ALU_SUB=1).
- Sub-modules:
  - One reusable sap_reg (DW-bit load/clear register) instantiated twice for A and B.
  - PC, ALU and bus mux stay inline.

Test Plan:
- Reset: load A=0x55, B=0xAA, PC=7, flags=1, then assert clr for one edge -> all of pc_q, a_q, b_q, cf, zf = 0.
- Load/add:
  - bus_in=0x38 with a_we -> a_q=0x38.
  - bus_in=0x23 with b_we -> b_q=0x23.
  - sum_oe+a_we+flags_we -> a_q=0x5B, bus_out during that cycle=0x5B, bus_oe=1, cf=0, zf=0.
- Subtract:
  - A=0x38, B=0x23, sub=1, flags_we -> bus result 0x15, cf=1, zf=0.
  - A=0x23, B=0x23 -> result 0x00, cf=1, zf=1.
  - A=0x00, B=0x01 -> 0xFF, cf=0.
- Add overflow: A=0xF0, B=0x20, flags_we -> result 0x10, cf=1, zf=0. A=0x80, B=0x80 -> 0x00, cf=1, zf=1.
- PC:
  - pc_oe+pc_inc at pc_q=0 -> bus_out=0x00, next pc_q=1.
  - Increment from 0xF -> 0x0.
  - pc_jmp with bus_in=0x3C and pc_inc -> pc_q=0xC (jmp wins).
- Bus priority/hold:
  - pc_oe and a_oe together -> bus_out = PC value.
  - No enables for several edges -> all registers and flags hold. A=0x5B, a_oe -> bus_out=0x5B.
